fir_stream_pipe: RTL and testbench

//   Parametrised, signed, pipelined direct-form FIR with valid/ready streaming on both sides.

---
 rtl/fir_pkg.sv | 36 +++
 rtl/fir_round_sat.sv | 52 +++++
 rtl/fir_stream_pipe.sv | 131 +++++++++++++
 tb/tb_fir_stream_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the streaming FIR: accumulator sizing and
// a generic signed saturator used when the output is clamped.
package fir_pkg;

  localparam int NTAPS_MAX = 64;
  localparam int WIDE_W    = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int nt);
    return dw + cw + clog2(nt);
  endfunction

  // Clamp v to the signed range of w bits; ovf flags that clamping happened.
  function automatic wide_t sat_to_w(input wide_t v, input int w, output logic ovf);
    wide_t hi;
    wide_t lo;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = ~hi;
    ovf = 1'b1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    ovf = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Output conditioning: round-half-up arithmetic shift of the accumulator, then
// wrap to DATA_W, or clamp to DATA_W when FIR_SAT_EN is defined.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int DATA_W    = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] data,
  output logic                     ovf
);

  localparam int HALF_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  // One extra bit so adding the half-LSB can never wrap.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] ext;
    ext = {a[ACC_W-1], a};
    if (OUT_SHIFT > 0) begin
      ext = ext + ($signed((ACC_W + 1)'(1)) <<< HALF_POS);
      ext = ext >>> OUT_SHIFT;
    end
    return ext;
  endfunction

  logic signed [ACC_W:0] r;
  assign r = round_shift(acc);

`ifdef FIR_SAT_EN
  wide_t sat;
  logic  sat_ovf;
  logic  unused_sat;

  always_comb begin
    sat_ovf = 1'b0;
    sat     = sat_to_w(wide_t'(r), DATA_W, sat_ovf);
  end

  assign data       = sat[DATA_W-1:0];
  assign ovf        = sat_ovf;
  assign unused_sat = ^sat[WIDE_W-1:DATA_W];
`else
  logic unused_hi;

  assign data      = r[DATA_W-1:0];
  assign ovf       = 1'b0;
  assign unused_hi = ^r[ACC_W:DATA_W];
`endif

endmodule

// File: rtl/fir_stream_pipe.sv
// Streaming signed FIR: history -> products -> adder tree -> round/saturate, all
// stages frozen together by one global advance. FIR_SAT_EN enables output clamping.
module fir_stream_pipe
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NTAPS     = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   data_out,
  output logic                       ovf,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1) << OUT_SHIFT;

  function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [COEF_W-1:0] b);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return ACC_W'(p);
  endfunction

  logic adv;
  logic accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Coefficient bank: written whenever strobed, even while the pipe is stalled.
  logic signed [COEF_W-1:0] coef [NTAPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= (k == 0) ? UNITY : '0;
    end else if (coef_we && (int'(coef_addr) < NTAPS)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  // Stage 0: sample history, shifts only on an accepted sample.
  logic signed [DATA_W-1:0] x_p0 [NTAPS];
  logic                     vld_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) x_p0[k] <= '0;
      vld_p0 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= accept;
      if (accept) begin
        x_p0[0] <= data_in;
        for (int k = 1; k < NTAPS; k++) x_p0[k] <= x_p0[k-1];
      end
    end
  end

  // Stage 1: per-tap products, sign-extended to the accumulator width.
  logic signed [ACC_W-1:0] prod_p1 [NTAPS];
  logic                    vld_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) prod_p1[k] <= '0;
      vld_p1 <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NTAPS; k++) prod_p1[k] <= mul_ext(x_p0[k], coef[k]);
      vld_p1 <= vld_p0;
    end
  end

  // Stage 2: single-cycle sum of all products.
  logic signed [ACC_W-1:0] sum_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic                    vld_p2;

  always_comb begin
    sum_p1 = '0;
    for (int k = 0; k < NTAPS; k++) sum_p1 = sum_p1 + prod_p1[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2 <= '0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      acc_p2 <= sum_p1;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 3: round/shift/saturate into the output register.
  logic signed [DATA_W-1:0] rs_data;
  logic                     rs_ovf;

  fir_round_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_round_sat (
    .acc (acc_p2),
    .data(rs_data),
    .ovf (rs_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_p2;
      data_out  <= rs_data;
      ovf       <= rs_ovf;
    end
  end

endmodule

// File: tb/tb_fir_stream_pipe.sv
// Directed bench for fir_stream_pipe with NTAPS=4, 16-bit data/coefs; saturation
// expectations follow FIR_SAT_EN. A second instance uses OUT_SHIFT=1 for rounding.
module tb_fir_stream_pipe;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, out_valid, out_ready, ovf, coef_we;
  logic signed [DW-1:0] data_in, data_out;
  logic signed [CW-1:0] coef_wdata;
  logic [AW-1:0]        coef_addr;

  logic                 in_valid_s, in_ready_s, out_valid_s, out_ready_s, ovf_s, coef_we_s;
  logic signed [DW-1:0] data_in_s, data_out_s;
  logic signed [CW-1:0] coef_wdata_s;
  logic [AW-1:0]        coef_addr_s;

  fir_stream_pipe #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT), .OUT_SHIFT(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .ovf(ovf),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  fir_stream_pipe #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT), .OUT_SHIFT(1)) u_shift (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .data_in(data_in_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .data_out(data_out_s), .ovf(ovf_s),
    .coef_we(coef_we_s), .coef_addr(coef_addr_s), .coef_wdata(coef_wdata_s)
  );

  int total = 0;
  int bad   = 0;
  int nedge = 0;
  int acc_edge;
  int ov_edge;

  logic signed [DW-1:0] got [$];
  logic                 got_ovf [$];
  logic signed [DW-1:0] gs [$];

  logic signed [DW-1:0] imp_in  [5] = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
  logic signed [DW-1:0] imp_exp [5] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0};
  logic signed [DW-1:0] co_exp  [5] = '{16'sd5, 16'sd5, 16'sd15, 16'sd15, 16'sd15};
  logic signed [DW-1:0] sat_in  [3] = '{16'sh7FFF, 16'sh8000, 16'sd0};
`ifdef FIR_SAT_EN
  logic signed [DW-1:0] sat_exp [3] = '{16'sh7FFF, 16'sh8000, 16'sd0};
  logic                 sat_ovf_exp [3] = '{1'b1, 1'b1, 1'b0};
`else
  logic signed [DW-1:0] sat_exp [3] = '{16'sh0001, 16'sh8000, 16'sd0};
  logic                 sat_ovf_exp [3] = '{1'b0, 1'b0, 1'b0};
`endif
  logic signed [DW-1:0] rnd_in  [3] = '{16'sd3, -16'sd3, 16'sd1};
  logic signed [DW-1:0] rnd_exp [4] = '{16'sd3, 16'sd2, -16'sd1, 16'sd1};

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] gv(input int i);
    if (i < got.size()) return 64'(got[i]);
    return 'x;
  endfunction

  function automatic logic signed [63:0] gov(input int i);
    if (i < got_ovf.size()) return {63'd0, got_ovf[i]};
    return 'x;
  endfunction

  function automatic logic signed [63:0] gsv(input int i);
    if (i < gs.size()) return 64'(gs[i]);
    return 'x;
  endfunction

  // One clock on the main instance: drive, sample mid-low-phase, then cross one rising edge.
  task automatic tick(input logic v, input logic signed [DW-1:0] d, input logic ordy, output logic acc);
    in_valid  = v;
    data_in   = d;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got.push_back(data_out);
      got_ovf.push_back(ovf);
    end
    if (out_valid && ov_edge < 0) ov_edge = nedge;
    if (acc && acc_edge < 0) acc_edge = nedge + 1;
    @(posedge clk);
    nedge++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_coef(input logic [AW-1:0] addr, input logic signed [CW-1:0] val);
    logic a;
    coef_addr  = addr;
    coef_wdata = val;
    coef_we    = 1'b1;
    tick(1'b0, '0, 1'b1, a);
    coef_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic held;
    logic stall;
    int   si;
    int   hold;

    rst = 1'b1;
    in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    in_valid_s = 1'b0; data_in_s = '0; out_ready_s = 1'b1;
    coef_we_s = 1'b0; coef_addr_s = '0; coef_wdata_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);

    for (int k = 0; k < NT; k++) wr_coef(AW'(k), CW'(k + 1));

    // Impulse response and latency.
    got.delete(); got_ovf.delete(); acc_edge = -1; ov_edge = -1; si = 0;
    for (int c = 0; c < 30 && got.size() < 5; c++) begin
      tick(si < 5, imp_in[si < 5 ? si : 0], 1'b1, a);
      if (a) si++;
    end
    chk("t1_count", got.size(), 5);
    chk("t1_latency", ov_edge - acc_edge, 3);
    for (int i = 0; i < 5; i++) chk($sformatf("t1_out%0d", i), gv(i), imp_exp[i]);

    // Backpressure while the second output is presented.
    got.delete(); got_ovf.delete(); si = 0; hold = 0; held = 1'b0;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      if (!held && out_valid && got.size() == 1) begin
        hold = 5;
        held = 1'b1;
      end
      stall = (hold > 0);
      if (stall) begin
        out_ready = 1'b0;
        in_valid  = (si < 5);
        #1;
        chk("t2_in_ready_hold", in_ready, 0);
        chk("t2_data_hold", data_out, 2);
        chk("t2_valid_hold", out_valid, 1);
        hold--;
      end
      tick(si < 5, imp_in[si < 5 ? si : 0], !stall, a);
      if (a) si++;
    end
    chk("t2_hold_seen", held, 1);
    chk("t2_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_out%0d", i), gv(i), imp_exp[i]);

    // Bubbles between samples.
    got.delete(); got_ovf.delete();
    for (int c = 0; c < 12; c++) tick((c == 0) || (c == 2), 16'sd1, 1'b1, a);
    chk("t3_count", got.size(), 2);
    chk("t3_out0", gv(0), 1);
    chk("t3_out1", gv(1), 3);

    // Coefficient write mid-stream, after reset restored unity gain.
    do_reset();
    got.delete(); got_ovf.delete();
    for (int c = 0; c < 13; c++) begin
      if (c == 2) begin
        coef_addr  = 2'd1;
        coef_wdata = 16'sd2;
        coef_we    = 1'b1;
      end
      tick(c < 5, 16'sd5, 1'b1, a);
      coef_we = 1'b0;
    end
    chk("t4_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t4_out%0d", i), gv(i), co_exp[i]);

    // Saturation or wrap at the range extremes; ovf is per beat.
    do_reset();
    wr_coef(2'd0, 16'sh7FFF);
    got.delete(); got_ovf.delete();
    for (int c = 0; c < 10; c++) tick(c < 3, sat_in[c < 3 ? c : 0], 1'b1, a);
    chk("t6_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_out%0d", i), gv(i), sat_exp[i]);
      chk($sformatf("t6_ovf%0d", i), gov(i), {63'd0, sat_ovf_exp[i]});
    end

    // Asynchronous reset with beats in flight.
    for (int c = 0; c < 10 && !out_valid; c++) tick(1'b1, 16'sd9, 1'b1, a);
    chk("t7_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_ready", in_ready, 1);
    chk("t7_rst_data", data_out, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got.delete(); got_ovf.delete();
    for (int c = 0; c < 10; c++) tick(c == 0, 16'sd7, 1'b1, a);
    chk("t7_count", got.size(), 1);
    chk("t7_out0", gv(0), 7);

    // Rounding on the OUT_SHIFT=1 instance: reset unity first, then coef0=1.
    gs.delete();
    for (int c = 0; c < 8; c++) begin
      in_valid_s = (c == 0);
      data_in_s  = rnd_in[0];
      #1;
      if (out_valid_s) gs.push_back(data_out_s);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid_s   = 1'b0;
    coef_addr_s  = 2'd0;
    coef_wdata_s = 16'sd1;
    coef_we_s    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    coef_we_s = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid_s = (c < 3);
      data_in_s  = rnd_in[c < 3 ? c : 0];
      #1;
      if (out_valid_s) gs.push_back(data_out_s);
      @(posedge clk);
      @(negedge clk);
    end
    chk("t5_count", gs.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_out%0d", i), gsv(i), rnd_exp[i]);
    chk("t5_ovf", ovf_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
